// File: rtl/glb_stream_src.sv
// Buffered valid/ready stream source: words are loaded into an internal buffer, then streamed
// after a flush pulse with optional LFSR-driven bubbles and repeated passes. done marks completion.
module glb_stream_src #(
  parameter  int DATA_WIDTH  = 17,
  parameter  int DEPTH       = 2048,
  parameter  int START_DELAY = 3,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_en,
  input  logic [AW-1:0]         ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic [AW:0]           cfg_tx_size,
  input  logic [AW-1:0]         cfg_base,
  input  logic [7:0]            cfg_repeat,
  input  logic [3:0]            cfg_stall_thr,
  input  logic [15:0]           cfg_seed,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  done
);

  localparam int          WW         = (START_DELAY < 2) ? 1 : $clog2(START_DELAY + 1);
  localparam logic [15:0] LFSR_RESET = 16'hACE1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [DATA_WIDTH-1:0] buf_mem [DEPTH];

  logic [2:0]            state_q,    state_d;
  logic [AW:0]           tx_size_q,  tx_size_d;
  logic [AW-1:0]         base_q,     base_d;
  logic [7:0]            repeat_q,   repeat_d;
  logic [3:0]            thr_q,      thr_d;
  logic [15:0]           lfsr_q,     lfsr_d;
  logic [AW-1:0]         rd_ptr_q,   rd_ptr_d;
  logic [AW:0]           beat_cnt_q, beat_cnt_d;
  logic [7:0]            pass_cnt_q, pass_cnt_d;
  logic [WW-1:0]         wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0] data_q,     data_d;
  logic                  valid_q,    valid_d;
  logic                  done_q,     done_d;

  logic hs;
  logic final_beat;

  // NOTE: the buffer has no reset; its contents survive rst_n and only ld_en changes them.
  always_ff @(posedge clk) begin
    if (ld_en && (state_q != S_STREAM)) buf_mem[ld_addr] <= ld_data;
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block infers a latch.
    state_d    = state_q;
    tx_size_d  = tx_size_q;
    base_d     = base_q;
    repeat_d   = repeat_q;
    thr_d      = thr_q;
    lfsr_d     = lfsr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_cnt_d = beat_cnt_q;
    pass_cnt_d = pass_cnt_q;
    wait_cnt_d = wait_cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    done_d     = done_q;
    hs         = valid_q && ready;
    final_beat = 1'b0;

    case (state_q)
      S_IDLE: if (flush) state_d = S_ARMED;

      S_ARMED: if (!flush) begin
        state_d    = S_WAIT;
        tx_size_d  = cfg_tx_size;
        base_d     = cfg_base;
        repeat_d   = cfg_repeat;
        thr_d      = cfg_stall_thr;
        lfsr_d     = (cfg_seed == 16'h0) ? LFSR_RESET : cfg_seed;
        rd_ptr_d   = cfg_base;
        beat_cnt_d = '0;
        pass_cnt_d = '0;
        wait_cnt_d = '0;
      end

      S_WAIT: begin
        if (flush) begin
          state_d = S_ARMED;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
          if (32'(wait_cnt_q) + 1 >= START_DELAY) begin
            if (tx_size_q == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_STREAM;
            end
          end
        end
      end

      S_STREAM: begin
        if (flush) begin
          // Abort: the beat in flight is dropped and the source re-arms.
          state_d = S_ARMED;
          valid_d = 1'b0;
          done_d  = 1'b0;
        end else begin
          lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
          if (hs) begin
            if (beat_cnt_q + (AW+1)'(1) == tx_size_q) begin
              beat_cnt_d = '0;
              rd_ptr_d   = base_q;
              pass_cnt_d = pass_cnt_q + 8'd1;
              final_beat = (pass_cnt_q == repeat_q);
            end else begin
              beat_cnt_d = beat_cnt_q + (AW+1)'(1);
              rd_ptr_d   = rd_ptr_q + AW'(1);
            end
          end
          if (final_beat) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else if (!valid_q || hs) begin
            // Bubbles only replace a load, so an asserted valid is never withdrawn.
            if (lfsr_q[3:0] < thr_q) begin
              valid_d = 1'b0;
            end else begin
              valid_d = 1'b1;
              data_d  = buf_mem[rd_ptr_d];
            end
          end
        end
      end

      S_DONE: if (flush) begin
        state_d = S_ARMED;
        done_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tx_size_q  <= '0;
      base_q     <= '0;
      repeat_q   <= '0;
      thr_q      <= '0;
      lfsr_q     <= LFSR_RESET;
      rd_ptr_q   <= '0;
      beat_cnt_q <= '0;
      pass_cnt_q <= '0;
      wait_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_size_q  <= tx_size_d;
      base_q     <= base_d;
      repeat_q   <= repeat_d;
      thr_q      <= thr_d;
      lfsr_q     <= lfsr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign done  = done_q;

endmodule

// File: tb/tb_glb_stream_src.sv
// Scoreboard bench for glb_stream_src: expected words are queued from a buffer model at run start
// and popped on every observed handshake; latency, bubbles, abort, wrap and reset are checked too.
module tb_glb_stream_src;
  localparam int DW    = 17;
  localparam int DEPTH = 2048;
  localparam int AW    = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic [AW:0]   cfg_tx_size = '0;
  logic [AW-1:0] cfg_base = '0;
  logic [7:0]    cfg_repeat = '0;
  logic [3:0]    cfg_stall_thr = '0;
  logic [15:0]   cfg_seed = '0;
  logic          flush = 1'b0;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready = 1'b1;
  logic          done;

  glb_stream_src #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .START_DELAY(3)) dut (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .cfg_tx_size(cfg_tx_size), .cfg_base(cfg_base), .cfg_repeat(cfg_repeat),
    .cfg_stall_thr(cfg_stall_thr), .cfg_seed(cfg_seed), .flush(flush),
    .data(data), .valid(valid), .ready(ready), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] exp_q [$];

  int hs_cnt, first_valid_edge, last_hs_edge, done_edge, bubbles, edge_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input int a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = AW'(a); ld_data = d; mdl[a] = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic push_expected(input int tx, input int base, input int rep);
    exp_q.delete();
    for (int p = 0; p <= rep; p++)
      for (int b = 0; b < tx; b++) exp_q.push_back(mdl[(base + b) % DEPTH]);
  endtask

  // rmode: 0 ready high, 1 ready toggling, 2 ready random. abort_after>0 aborts after that many beats.
  task automatic run(input int tx, input int base, input int rep, input int thr,
                     input int seed, input int rmode, input int abort_after);
    logic          prev_valid, prev_ready, aborted;
    logic [DW-1:0] prev_data;
    int            cyc;
    cfg_tx_size = (AW+1)'(tx); cfg_base = AW'(base); cfg_repeat = 8'(rep);
    cfg_stall_thr = 4'(thr); cfg_seed = 16'(seed);
    push_expected(tx, base, rep);
    ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    hs_cnt = 0; first_valid_edge = -1; last_hs_edge = -1; done_edge = -1;
    bubbles = 0; edge_cnt = -1; cyc = 0;
    prev_valid = 1'b0; prev_ready = 1'b1; prev_data = '0; aborted = 1'b0;
    while (1) begin
      @(negedge clk);
      if (valid && ready) begin
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else check("beat_data", 32'(data), 32'(exp_q.pop_front()));
        hs_cnt++;
        last_hs_edge = edge_cnt;
      end
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 32'(valid), 1);
        check("hold_data", 32'(data), 32'(prev_data));
      end
      if (valid && first_valid_edge < 0) first_valid_edge = edge_cnt;
      if (!valid && first_valid_edge >= 0 && !done) bubbles++;
      prev_valid = valid; prev_ready = ready; prev_data = data;
      if (done) begin
        done_edge = edge_cnt;
        check("done_valid_low", 32'(valid), 0);
        break;
      end
      if (cyc > 5000) begin
        check("timeout_done", 0, 1);
        break;
      end
      @(posedge clk); #1;
      edge_cnt++; cyc++;
      if (abort_after > 0 && !aborted && hs_cnt == abort_after) begin
        flush = 1'b1; ready = 1'b0;
        @(posedge clk); #1;
        check("abort_valid", 32'(valid), 0);
        check("abort_done", 32'(done), 0);
        flush = 1'b0; ready = 1'b1; aborted = 1'b1;
        push_expected(tx, base, rep);
        hs_cnt = 0; first_valid_edge = -1; last_hs_edge = -1;
        bubbles = 0; edge_cnt = -1; prev_valid = 1'b0;
      end else begin
        case (rmode)
          1:       ready = ~ready;
          2:       ready = 1'($urandom_range(0, 1));
          default: ready = 1'b1;
        endcase
      end
    end
    check("queue_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_data", 32'(data), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_done", 32'(done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) load(i, DW'(i));
    load(2046, 17'h12345);
    load(2047, 17'h0BEEF);

    // Basic single pass: latency, back-to-back beats, done timing.
    run(8, 0, 0, 0, 16'h1234, 0, 0);
    check("t1_first_valid", 32'(first_valid_edge), 4);
    check("t1_hs", 32'(hs_cnt), 8);
    check("t1_done_timing", 32'(done_edge), 32'(last_hs_edge + 1));
    check("t1_bubbles", 32'(bubbles), 0);

    // Toggling ready: each word held until accepted.
    run(8, 0, 0, 0, 16'h1234, 1, 0);
    check("t2_hs", 32'(hs_cnt), 8);
    check("t2_bubbles", 32'(bubbles), 0);

    // Address wrap past the top of the buffer.
    run(4, 2046, 0, 0, 16'h0, 0, 0);
    check("t3_hs", 32'(hs_cnt), 4);

    // Repeat mode: three passes over buf[5..7].
    run(3, 5, 2, 0, 16'h0, 0, 0);
    check("t4_hs", 32'(hs_cnt), 9);

    // Heavy bubble injection with random ready.
    run(8, 0, 0, 15, 16'h0001, 2, 0);
    check("t5_hs", 32'(hs_cnt), 8);
    check("t5_bubbles_seen", 32'(bubbles > 0), 1);

    // Abort after two beats, then restart from base.
    run(8, 0, 0, 0, 16'h0, 0, 2);
    check("t6_hs", 32'(hs_cnt), 8);
    check("t6_first_valid", 32'(first_valid_edge), 4);

    // Zero-length transfer: done without any valid.
    run(0, 0, 0, 0, 16'h0, 0, 0);
    check("t7_hs", 32'(hs_cnt), 0);
    check("t7_no_valid", 32'(first_valid_edge < 0), 1);
    check("t7_done", 32'(done), 1);

    // Asynchronous reset mid-stream.
    cfg_tx_size = 12'd8; cfg_base = '0; cfg_repeat = '0; cfg_stall_thr = '0;
    ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < 50 && !(valid && data == DW'(3)); i++) @(negedge clk);
    check("t8_mid_stream", 32'(valid && data == DW'(3)), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t8_rst_data", 32'(data), 0);
    check("t8_rst_valid", 32'(valid), 0);
    check("t8_rst_done", 32'(done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t8_idle_valid", 32'(valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
